// File: rtl/core_mem_arb_pkg.sv
// Shared types and sizing helpers for the core memory arbiter.
package core_mem_arb_pkg;

  // Arbiter FSM: IDLE accepts a request, WAIT holds the single outstanding access.
  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StWait = 1'b1
  } arb_state_e;

  // Which requester owns the outstanding access.
  typedef enum logic {
    OwnInst = 1'b0,
    OwnLsu  = 1'b1
  } owner_e;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val < 2) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/core_mem_arb_sel.sv
// Winner select between fetch and LSU: LSU priority, except that fetch wins once the
// LSU has taken LSU_BURST_MAX consecutive grants while fetch was waiting.
module core_mem_arb_sel
  import core_mem_arb_pkg::*;
#(
  parameter int unsigned LSU_BURST_MAX = 4,
  parameter int unsigned StreakW       = cnt_width(LSU_BURST_MAX)
) (
  input  logic               inst_req_en,
  input  logic               lsu_req_en,
  input  logic [StreakW-1:0] streak,
  output logic               gnt_inst,
  output logic               gnt_lsu
);

  localparam logic [StreakW-1:0] StreakMax = StreakW'(LSU_BURST_MAX);

  logic starve;

  // Starvation override only applies when both sides are asking.
  always_comb begin
    starve   = inst_req_en && lsu_req_en && (streak == StreakMax);
    gnt_lsu  = lsu_req_en && !starve;
    gnt_inst = inst_req_en && (!lsu_req_en || starve);
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one single-ported core memory between instruction fetch and the LSU.
// One access outstanding at a time; completions are routed back to the owner, and a
// watchdog returns an error completion if the memory never answers.
module core_mem_arbiter
  import core_mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned LSU_BURST_MAX = 4,
  parameter int unsigned TIMEOUT_CYC   = 255
) (
  input  logic                  CLK,
  input  logic                  RST,

  // Instruction fetch requester
  input  logic                  inst_req_en,
  input  logic [ADDR_WIDTH-1:0] inst_req_addr,
  input  logic [DATA_WIDTH-1:0] inst_req_wdata,
  input  logic [STRB_WIDTH-1:0] inst_req_wen,
  output logic                  inst_req_rdy,
  output logic                  inst_rsp_rvld,
  output logic [DATA_WIDTH-1:0] inst_rsp_rdata,
  output logic                  inst_rsp_err,

  // LSU requester
  input  logic                  lsu_req_en,
  input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
  input  logic [DATA_WIDTH-1:0] lsu_req_wdata,
  input  logic [STRB_WIDTH-1:0] lsu_req_wen,
  output logic                  lsu_req_rdy,
  output logic                  lsu_rsp_rvld,
  output logic [DATA_WIDTH-1:0] lsu_rsp_rdata,
  output logic                  lsu_rsp_err,

  // Memory side
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [STRB_WIDTH-1:0] mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvld
);

  localparam int unsigned        TimerW    = cnt_width(TIMEOUT_CYC - 1);
  localparam int unsigned        StreakW   = cnt_width(LSU_BURST_MAX);
  localparam logic [TimerW-1:0]  TimerLast = TimerW'(TIMEOUT_CYC - 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(LSU_BURST_MAX);

  arb_state_e          state_q;
  owner_e              owner_q;
  logic [TimerW-1:0]   timer_q;
  logic [StreakW-1:0]  streak_q;
  logic [StreakW-1:0]  streak_nxt;

  logic                gnt_inst;
  logic                gnt_lsu;
  logic                can_accept;
  logic                done;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_WIDTH-1:0] sel_wen;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  core_mem_arb_sel #(
    .LSU_BURST_MAX (LSU_BURST_MAX),
    .StreakW       (StreakW)
  ) u_sel (
    .inst_req_en (inst_req_en),
    .lsu_req_en  (lsu_req_en),
    .streak      (streak_q),
    .gnt_inst    (gnt_inst),
    .gnt_lsu     (gnt_lsu)
  );

  // Accept pulses, winning request fields and the streak update for this grant.
  always_comb begin
    // Held off while RST is high so nothing looks accepted during a reset cycle.
    can_accept   = (state_q == StIdle) && !RST;
    inst_req_rdy = can_accept && gnt_inst;
    lsu_req_rdy  = can_accept && gnt_lsu;

    sel_addr  = gnt_lsu ? lsu_req_addr  : inst_req_addr;
    sel_wdata = gnt_lsu ? lsu_req_wdata : inst_req_wdata;
    sel_wen   = gnt_lsu ? lsu_req_wen   : inst_req_wen;

    streak_nxt = streak_q;
    if (gnt_inst) begin
      streak_nxt = '0;
    end else if (gnt_lsu) begin
      if (!inst_req_en) begin
        streak_nxt = '0;
      end else if (streak_q != StreakMax) begin
        streak_nxt = streak_q + StreakW'(1);
      end
    end
  end

  // Completion: memory answer wins over a timeout landing in the same cycle.
  always_comb begin
    done     = mem_rvld || (timer_q == TimerLast);
    rsp_data = mem_rvld ? mem_rdata : '0;
    rsp_err  = !mem_rvld;
  end

  // Arbiter FSM with registered memory command and response outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= StIdle;
      owner_q        <= OwnInst;
      timer_q        <= '0;
      streak_q       <= '0;
      mem_en         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_wen        <= '0;
      inst_rsp_rvld  <= 1'b0;
      inst_rsp_rdata <= '0;
      inst_rsp_err   <= 1'b0;
      lsu_rsp_rvld   <= 1'b0;
      lsu_rsp_rdata  <= '0;
      lsu_rsp_err    <= 1'b0;
    end else begin
      // Command and completion strobes are single-cycle; command fields read 0 when idle.
      mem_en        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wen       <= '0;
      inst_rsp_rvld <= 1'b0;
      inst_rsp_err  <= 1'b0;
      lsu_rsp_rvld  <= 1'b0;
      lsu_rsp_err   <= 1'b0;

      unique case (state_q)
        StIdle: begin
          // mem_rvld here is late or spurious and deliberately ignored.
          if (gnt_inst || gnt_lsu) begin
            state_q   <= StWait;
            owner_q   <= gnt_lsu ? OwnLsu : OwnInst;
            timer_q   <= '0;
            streak_q  <= streak_nxt;
            mem_en    <= 1'b1;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_wen   <= sel_wen;
          end
        end
        StWait: begin
          if (done) begin
            state_q <= StIdle;
            timer_q <= '0;
            if (owner_q == OwnLsu) begin
              lsu_rsp_rvld  <= 1'b1;
              lsu_rsp_rdata <= rsp_data;
              lsu_rsp_err   <= rsp_err;
            end else begin
              inst_rsp_rvld  <= 1'b1;
              inst_rsp_rdata <= rsp_data;
              inst_rsp_err   <= rsp_err;
            end
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter with a completion scoreboard.
module tb_core_mem_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned SW = 4;

  logic          CLK;
  logic          RST;
  logic          inst_req_en;
  logic [AW-1:0] inst_req_addr;
  logic [DW-1:0] inst_req_wdata;
  logic [SW-1:0] inst_req_wen;
  logic          inst_req_rdy;
  logic          inst_rsp_rvld;
  logic [DW-1:0] inst_rsp_rdata;
  logic          inst_rsp_err;
  logic          lsu_req_en;
  logic [AW-1:0] lsu_req_addr;
  logic [DW-1:0] lsu_req_wdata;
  logic [SW-1:0] lsu_req_wen;
  logic          lsu_req_rdy;
  logic          lsu_rsp_rvld;
  logic [DW-1:0] lsu_rsp_rdata;
  logic          lsu_rsp_err;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wen;
  logic [DW-1:0] mem_rdata;
  logic          mem_rvld;

  core_mem_arbiter #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .STRB_WIDTH    (SW),
    .LSU_BURST_MAX (4),
    .TIMEOUT_CYC   (16)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .inst_req_en    (inst_req_en),
    .inst_req_addr  (inst_req_addr),
    .inst_req_wdata (inst_req_wdata),
    .inst_req_wen   (inst_req_wen),
    .inst_req_rdy   (inst_req_rdy),
    .inst_rsp_rvld  (inst_rsp_rvld),
    .inst_rsp_rdata (inst_rsp_rdata),
    .inst_rsp_err   (inst_rsp_err),
    .lsu_req_en     (lsu_req_en),
    .lsu_req_addr   (lsu_req_addr),
    .lsu_req_wdata  (lsu_req_wdata),
    .lsu_req_wen    (lsu_req_wen),
    .lsu_req_rdy    (lsu_req_rdy),
    .lsu_rsp_rvld   (lsu_rsp_rvld),
    .lsu_rsp_rdata  (lsu_rsp_rdata),
    .lsu_rsp_err    (lsu_rsp_err),
    .mem_en         (mem_en),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wen        (mem_wen),
    .mem_rdata      (mem_rdata),
    .mem_rvld       (mem_rvld)
  );

  typedef struct {
    logic          own;   // 0 = fetch, 1 = LSU
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=no finish expected=finish before time limit");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic own, input logic [DW-1:0] d, input logic e);
    exp_t x;
    x.own  = own;
    x.data = d;
    x.err  = e;
    sb.push_back(x);
  endtask

  // Scoreboard: every completion must match the oldest expected entry.
  always @(negedge CLK) begin
    exp_t e;
    if (inst_rsp_rvld || lsu_rsp_rvld) begin
      checks++;
      assert (sb.size() > 0)
      else begin
        failures++;
        $error("FAIL sb_unexpected observed=inst:%b lsu:%b expected=no completion",
               inst_rsp_rvld, lsu_rsp_rvld);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_both", 32'(inst_rsp_rvld & lsu_rsp_rvld), 32'd0);
        chk("sb_owner", 32'(lsu_rsp_rvld), 32'(e.own));
        chk("sb_rdata", lsu_rsp_rvld ? lsu_rsp_rdata : inst_rsp_rdata, e.data);
        chk("sb_err", 32'(lsu_rsp_rvld ? lsu_rsp_err : inst_rsp_err), 32'(e.err));
      end
    end
  end

  initial begin
    RST = 1'b1;
    inst_req_en = 1'b0; inst_req_addr = '0; inst_req_wdata = '0; inst_req_wen = '0;
    lsu_req_en = 1'b0;  lsu_req_addr = '0;  lsu_req_wdata = '0;  lsu_req_wen = '0;
    mem_rdata = '0; mem_rvld = 1'b0;

    // Reset values, with requests asserted to show no accept during reset
    repeat (3) tick();
    inst_req_en = 1'b1; lsu_req_en = 1'b1;
    settle();
    chk("rst_inst_rdy",   32'(inst_req_rdy), 32'd0);
    chk("rst_lsu_rdy",    32'(lsu_req_rdy), 32'd0);
    chk("rst_mem_en",     32'(mem_en), 32'd0);
    chk("rst_mem_addr",   mem_addr, 32'd0);
    chk("rst_mem_wdata",  mem_wdata, 32'd0);
    chk("rst_mem_wen",    32'(mem_wen), 32'd0);
    chk("rst_inst_rvld",  32'(inst_rsp_rvld), 32'd0);
    chk("rst_inst_err",   32'(inst_rsp_err), 32'd0);
    chk("rst_inst_rdata", inst_rsp_rdata, 32'd0);
    chk("rst_lsu_rvld",   32'(lsu_rsp_rvld), 32'd0);
    chk("rst_lsu_err",    32'(lsu_rsp_err), 32'd0);
    chk("rst_lsu_rdata",  lsu_rsp_rdata, 32'd0);
    inst_req_en = 1'b0; lsu_req_en = 1'b0;
    tick();
    RST = 1'b0;
    tick();

    // Single fetch, memory answers two cycles after mem_en
    inst_req_en = 1'b1; inst_req_addr = 32'hFFFF_0004; inst_req_wen = 4'b0000;
    settle();
    chk("f1_inst_rdy", 32'(inst_req_rdy), 32'd1);
    chk("f1_lsu_rdy",  32'(lsu_req_rdy), 32'd0);
    push(1'b0, 32'h0000_0013, 1'b0);
    tick();
    inst_req_en = 1'b0;
    chk("f1_mem_en",   32'(mem_en), 32'd1);
    chk("f1_mem_addr", mem_addr, 32'hFFFF_0004);
    chk("f1_mem_wen",  32'(mem_wen), 32'd0);
    tick();
    chk("f1_mem_en_drop",   32'(mem_en), 32'd0);
    chk("f1_mem_addr_zero", mem_addr, 32'd0);
    tick();
    mem_rvld = 1'b1; mem_rdata = 32'h0000_0013;
    tick();
    mem_rvld = 1'b0; mem_rdata = '0;
    chk("f1_rsp_rvld",  32'(inst_rsp_rvld), 32'd1);
    chk("f1_rsp_rdata", inst_rsp_rdata, 32'h0000_0013);
    chk("f1_lsu_rvld",  32'(lsu_rsp_rvld), 32'd0);
    tick();
    chk("f1_rvld_pulse", 32'(inst_rsp_rvld), 32'd0);
    chk("f1_rdata_hold", inst_rsp_rdata, 32'h0000_0013);

    // Simultaneous requests: LSU first, fetch granted in the LSU completion cycle
    inst_req_en = 1'b1; inst_req_addr = 32'h0000_0100;
    lsu_req_en  = 1'b1; lsu_req_addr  = 32'h0000_0200; lsu_req_wen = 4'b0000;
    settle();
    chk("s_lsu_rdy",  32'(lsu_req_rdy), 32'd1);
    chk("s_inst_rdy", 32'(inst_req_rdy), 32'd0);
    push(1'b1, 32'hAAAA_0001, 1'b0);
    tick();
    lsu_req_en = 1'b0;
    mem_rvld = 1'b1; mem_rdata = 32'hAAAA_0001;
    settle();
    chk("s_mem_addr_lsu", mem_addr, 32'h0000_0200);
    chk("s_inst_rdy_wait", 32'(inst_req_rdy), 32'd0);
    tick();
    mem_rvld = 1'b0;
    settle();
    chk("s_lsu_rvld", 32'(lsu_rsp_rvld), 32'd1);
    chk("s_inst_rdy_at_rsp", 32'(inst_req_rdy), 32'd1);
    push(1'b0, 32'hBBBB_0002, 1'b0);
    tick();
    inst_req_en = 1'b0;
    mem_rvld = 1'b1; mem_rdata = 32'hBBBB_0002;
    chk("s_mem_addr_inst", mem_addr, 32'h0000_0100);
    tick();
    mem_rvld = 1'b0;
    chk("s_inst_rvld", 32'(inst_rsp_rvld), 32'd1);

    // Starvation: both requesting continuously, expect L,L,L,L,I,L,L,L,L,I
    for (int i = 0; i < 10; i++) begin
      logic exp_lsu;
      exp_lsu = (i % 5) != 4;
      tick();
      inst_req_en = 1'b1; inst_req_addr = 32'h0000_1000 + 32'(i * 4);
      lsu_req_en  = 1'b1; lsu_req_addr  = 32'h0000_2000 + 32'(i * 4);
      mem_rvld = 1'b0;
      settle();
      chk("starve_lsu_rdy",  32'(lsu_req_rdy), 32'(exp_lsu));
      chk("starve_inst_rdy", 32'(inst_req_rdy), 32'(!exp_lsu));
      push(exp_lsu, 32'hC000_0000 + 32'(i), 1'b0);
      tick();
      mem_rvld = 1'b1; mem_rdata = 32'hC000_0000 + 32'(i);
      settle();
      chk("starve_no_rdy_wait", 32'(inst_req_rdy | lsu_req_rdy), 32'd0);
    end
    tick();
    inst_req_en = 1'b0; lsu_req_en = 1'b0; mem_rvld = 1'b0;
    tick();

    // LSU partial write
    lsu_req_en = 1'b1; lsu_req_addr = 32'hFFFF_1008;
    lsu_req_wdata = 32'hA5A5_1234; lsu_req_wen = 4'b0011;
    settle();
    chk("w_lsu_rdy", 32'(lsu_req_rdy), 32'd1);
    push(1'b1, 32'h0000_5A5A, 1'b0);
    tick();
    lsu_req_en = 1'b0;
    chk("w_mem_en",    32'(mem_en), 32'd1);
    chk("w_mem_addr",  mem_addr, 32'hFFFF_1008);
    chk("w_mem_wdata", mem_wdata, 32'hA5A5_1234);
    chk("w_mem_wen",   32'(mem_wen), 32'b0011);
    tick();
    chk("w_mem_wen_zero",   32'(mem_wen), 32'd0);
    chk("w_mem_wdata_zero", mem_wdata, 32'd0);
    mem_rvld = 1'b1; mem_rdata = 32'h0000_5A5A;
    tick();
    mem_rvld = 1'b0; mem_rdata = '0;
    chk("w_lsu_rvld", 32'(lsu_rsp_rvld), 32'd1);
    tick();
    chk("w_lsu_rvld_pulse", 32'(lsu_rsp_rvld), 32'd0);

    // Timeout: no answer, error completion at T+17, late mem_rvld ignored
    inst_req_en = 1'b1; inst_req_addr = 32'h0000_0040; inst_req_wen = 4'b0000;
    settle();
    chk("to_inst_rdy", 32'(inst_req_rdy), 32'd1);
    push(1'b0, 32'd0, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      tick();
      inst_req_en = 1'b0;
      lsu_req_en  = (k == 3);
      settle();
      chk("to_no_rvld_early", 32'(inst_rsp_rvld), 32'd0);
      if (k == 3) chk("to_lsu_rdy_in_wait", 32'(lsu_req_rdy), 32'd0);
    end
    tick();
    chk("to_rvld",  32'(inst_rsp_rvld), 32'd1);
    chk("to_err",   32'(inst_rsp_err), 32'd1);
    chk("to_rdata", inst_rsp_rdata, 32'd0);
    tick();
    tick();
    tick();
    mem_rvld = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rvld = 1'b0; mem_rdata = '0;
    chk("to_late_inst_rvld", 32'(inst_rsp_rvld), 32'd0);
    chk("to_late_lsu_rvld",  32'(lsu_rsp_rvld), 32'd0);
    chk("to_late_mem_en",    32'(mem_en), 32'd0);
    chk("to_late_rdata",     inst_rsp_rdata, 32'd0);

    // Reset in the cycle after mem_en abandons the access
    tick();
    inst_req_en = 1'b1; inst_req_addr = 32'h0000_0080;
    settle();
    chk("r_inst_rdy", 32'(inst_req_rdy), 32'd1);
    tick();
    inst_req_en = 1'b0;
    chk("r_mem_en", 32'(mem_en), 32'd1);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    mem_rvld = 1'b1; mem_rdata = 32'h7777_7777;
    chk("r_mem_en_zero",    32'(mem_en), 32'd0);
    chk("r_inst_rvld_zero", 32'(inst_rsp_rvld), 32'd0);
    chk("r_lsu_rdata_zero", lsu_rsp_rdata, 32'd0);
    tick();
    mem_rvld = 1'b0; mem_rdata = '0;
    chk("r_no_inst_rvld", 32'(inst_rsp_rvld), 32'd0);
    chk("r_no_lsu_rvld",  32'(lsu_rsp_rvld), 32'd0);
    inst_req_en = 1'b1; inst_req_addr = 32'h0000_0084;
    settle();
    chk("r_new_inst_rdy", 32'(inst_req_rdy), 32'd1);
    push(1'b0, 32'h1234_5678, 1'b0);
    tick();
    inst_req_en = 1'b0;
    mem_rvld = 1'b1; mem_rdata = 32'h1234_5678;
    chk("r_new_mem_addr", mem_addr, 32'h0000_0084);
    tick();
    mem_rvld = 1'b0; mem_rdata = '0;
    chk("r_new_rvld", 32'(inst_rsp_rvld), 32'd1);
    chk("r_new_rdata", inst_rsp_rdata, 32'h1234_5678);

    repeat (3) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Shares one single-ported core memory between the instruction-fetch requester and the LSU requester. It sits below the core bus address decoders, in front of a unified instruction/data SRAM. It arbitrates with LSU priority plus a starvation limit for fetch, keeps one transaction outstanding at a time, and routes each completion back to its owner. A watchdog returns an error completion if the memory never answers.

## Interface
Parameters:
- DATA_WIDTH, 32: data bus width.
- ADDR_WIDTH, 32: address width.
- STRB_WIDTH, DATA_WIDTH/8: byte write-enable width.
- LSU_BURST_MAX, 4: consecutive LSU grants allowed while fetch waits.
- TIMEOUT_CYC, 255: WAIT cycles before error completion; minimum 2.

Ports:
- CLK, in, 1: single clock; all logic on its rising edge.
- RST, in, 1: synchronous, active-high reset.
- inst_req_en, in, 1: fetch request valid; held until accepted.
- inst_req_addr / inst_req_wdata / inst_req_wen, in, ADDR/DATA/STRB: fetch request fields; wen = 0 means read.
- inst_req_rdy, out, 1: combinational accept pulse for fetch.
- inst_rsp_rvld / inst_rsp_rdata / inst_rsp_err, out, 1/DATA/1: registered fetch completion.
- lsu_req_en, lsu_req_addr, lsu_req_wdata, lsu_req_wen, lsu_req_rdy, lsu_rsp_rvld, lsu_rsp_rdata, lsu_rsp_err: same as the fetch set, for the LSU.
- mem_en / mem_addr / mem_wdata / mem_wen, out, 1/ADDR/DATA/STRB: registered memory command.
- mem_rdata, in, DATA: memory read data.
- mem_rvld, in, 1: memory completion pulse, one per access (reads and writes).

## Operation
- States: IDLE, WAIT.
- IDLE:
  - If any req_en is high, pick a winner, assert its req_rdy that cycle, latch its fields and owner, and go to WAIT.
  - Arbitration:
    - LSU wins.
    - Exception: fetch wins when both are requesting and streak == LSU_BURST_MAX.
    - Fetch alone wins.
- streak counter:
  - Increments on an LSU grant while inst_req_en is high.
  - Clears on a fetch grant, and on an LSU grant with inst_req_en low.
  - Saturates at LSU_BURST_MAX.
- WAIT:
  - Count timer each cycle.
  - mem_rvld: capture mem_rdata into the owner's rsp_rdata, pulse the owner's rsp_rvld, go to IDLE.
  - timer == TIMEOUT_CYC-1 with no mem_rvld: pulse rsp_rvld and rsp_err, rsp_rdata = 0, go to IDLE.
- req_rdy is never asserted in WAIT; at most one transaction is outstanding.
- The non-owner's rsp_rdata holds its last value.
- mem_rvld while in IDLE (late or spurious) is ignored.
- No address decoding is done here; addresses pass through unchanged.

## Timing
- Reset values:
  - State IDLE; streak = 0; timer = 0.
  - All mem_* outputs 0.
  - All rsp_rvld, rsp_err and rsp_rdata 0.
  - req_rdy outputs 0.
- Accept at cycle T (req_rdy high) → mem_en = 1 for exactly cycle T+1, with latched addr, wdata and wen. mem_addr, mem_wdata and mem_wen return to 0 when mem_en is low.
- mem_rvld is valid from T+1 onward, including in the mem_en cycle.
- mem_rvld at cycle R → rsp_rvld and rsp_rdata at R+1, for one cycle. The FSM is in IDLE at R+1, so the next grant can happen at R+1.
- Minimum issue interval is 2 cycles (mem_rvld in the mem_en cycle).
- Timeout: err completion at cycle T+1+TIMEOUT_CYC.
- Simultaneous mem_rvld and timeout in the same cycle: mem_rvld wins, no error.
- A request dropped before rdy is allowed; nothing is latched.
- RST mid-WAIT: next cycle is IDLE with all outputs 0; the abandoned completion is never delivered.

## Structure
- Package core_mem_arb_pkg:
  - State enum (IDLE, WAIT).
  - Owner encoding (OWN_INST = 0, OWN_LSU = 1).
  - Width of timer and streak derived from the parameters.
- One sub-module, core_mem_arb_sel: combinational winner select from the two req_en inputs and streak; outputs gnt_inst and gnt_lsu.
- FSM, timer, latches and response registers live in the top module.

## Test plan
- Single fetch: inst addr 0xFFFF_0004; memory answers 0x0000_0013 two cycles after mem_en. Expect:
  - inst_rdy at T, mem_en at T+1 only.
  - inst_rsp_rvld one cycle with rdata 0x0000_0013.
  - lsu_rsp_rvld stays 0.
- Simultaneous requests from IDLE. Expect:
  - LSU granted first.
  - Fetch granted in the cycle its rsp_rvld... no: fetch granted in the cycle the LSU rsp_rvld is high.
  - Completions in order LSU, INST.
- Starvation with LSU_BURST_MAX = 4, both requesting continuously. Expect grant order L,L,L,L,I,L,L,L,L,I.
- LSU write: addr 0xFFFF_1008, wdata 0xA5A5_1234, wen 4'b0011. Expect:
  - mem_wen = 0011 and mem_wdata matching during the mem_en cycle.
  - lsu_rsp_rvld one cycle after mem_rvld.
- Timeout with TIMEOUT_CYC = 16 and no mem_rvld. Expect:
  - err and rvld at T+17, rdata 0.
  - mem_rvld injected at T+20 is ignored.
- RST asserted the cycle after mem_en. Expect:
  - All outputs 0 next cycle.
  - A following mem_rvld produces no rsp_rvld.
  - A new fetch is serviced normally.
